// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one synchronous font ROM between two pixel-pipeline requesters.
//   Port 0 is the board mine-index drawer. Port 1 is the HUD drawer.
//   At most one address is granted per cycle. The winner's address is registered onto
//   rom_addr. A {valid, port} tag travels ROM_LAT+1 stages beside the ROM, so each returned
//   line is steered to its owner with a one-cycle rvalid strobe.
// Ports:
//   clk, rst                 pixel clock, asynchronous active-low reset
//   req0/addr0/gnt0          port-0 request, address and combinational grant
//   rvalid0/rdata0           port-0 returned line (rdata0 is 0 when not owned)
//   req1/addr1/gnt1          port-1 request, address and combinational grant
//   rvalid1/rdata1           port-1 returned line (rdata1 is 0 when not owned)
//   rom_addr/rom_data        registered ROM address, ROM output line
//   busy                     at least one access is in flight
// Optional feature: define FONT_ARB_PORT0_PRIO_EN to give port 0 fixed priority, with a
//   starvation bound of MAX_WAIT waiting cycles for port 1. It replaces round-robin.
module font_rom_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 50,
    parameter int ROM_LAT  = 1,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    // Stage 0 lines up with rom_addr. Stage ROM_LAT lines up with rom_data.
    localparam int STAGES = ROM_LAT + 1;

    logic [STAGES-1:0] tag_vld;
    logic [STAGES-1:0] tag_port;

`ifdef FONT_ARB_PORT0_PRIO_EN
    logic [3:0] wait0;
    logic [3:0] wait1;

    // Port 0 wins unless port 1 has waited MAX_WAIT cycles.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req1 && (!req0 || (wait1 >= 4'(MAX_WAIT)))) begin
            gnt1 = 1'b1;
        end else if (req0) begin
            gnt0 = 1'b1;
        end
    end

    // Each wait counter saturates at 15. It clears on a grant or when req drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait0 <= '0;
            wait1 <= '0;
        end else begin
            if (!req0 || gnt0) begin
                wait0 <= '0;
            end else if (wait0 != 4'hf) begin
                wait0 <= wait0 + 4'd1;
            end
            if (!req1 || gnt1) begin
                wait1 <= '0;
            end else if (wait1 != 4'hf) begin
                wait1 <= wait1 + 4'd1;
            end
        end
    end
`else
    logic rr_last;

    // On contention, grant the port that was not granted last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            gnt0 = rr_last;
            gnt1 = !rr_last;
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
    end

    // The reset value of 1 lets port 0 win the first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last <= 1'b1;
        end else if (gnt0 || gnt1) begin
            rr_last <= gnt1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr <= '0;
            tag_vld  <= '0;
            tag_port <= '0;
        end else begin
            if (gnt0) begin
                rom_addr <= addr0;
            end else if (gnt1) begin
                rom_addr <= addr1;
            end
            tag_vld  <= {tag_vld[STAGES-2:0], gnt0 | gnt1};
            tag_port <= {tag_port[STAGES-2:0], gnt1};
        end
    end

    always_comb begin
        rvalid0 = tag_vld[ROM_LAT] & ~tag_port[ROM_LAT];
        rvalid1 = tag_vld[ROM_LAT] & tag_port[ROM_LAT];
        rdata0  = rvalid0 ? rom_data : '0;
        rdata1  = rvalid1 ? rom_data : '0;
        busy    = |tag_vld;
    end

endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
- Shares one synchronous number/character font ROM between two pixel-pipeline requesters.
  - Port 0: the board mine-index drawer.
  - Port 1: the HUD drawer (mine counter / timer digits).
- Grants at most one address per cycle, registers the address towards the ROM, and tags each in-flight access so the returned line is steered back to the correct requester with a valid strobe.
- Sits between the draw modules and the font ROM inside the redraw-board top.

Parameters:
- ADDR_W, 13, ROM address width ({char_code, char_line}).
- DATA_W, 50, ROM line width in pixels.
- ROM_LAT, 1, ROM read latency in cycles from rom_addr to rom_data (1..4).
- MAX_WAIT, 3, starvation bound used only with the optional feature (1..15).

Ports:
- clk  in  1  system pixel clock
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- req0  in  1  port-0 read request
- addr0  in  ADDR_W  port-0 address, valid with req0
- gnt0  out  1  port-0 grant, combinational, same cycle as req0
- rvalid0  out  1  port-0 read data valid
- rdata0  out  DATA_W  port-0 read data
- req1  in  1  port-1 read request
- addr1  in  ADDR_W  port-1 address
- gnt1  out  1  port-1 grant
- rvalid1  out  1  port-1 read data valid
- rdata1  out  DATA_W  port-1 read data
- rom_addr  out  ADDR_W  registered address to font ROM
- rom_data  in  DATA_W  font ROM output
- busy  out  1  any access in flight

Behaviour:
- Reset (rst=0, asynchronous):
  - rom_addr=0, tag pipeline cleared.
  - rr_last=1, so port 0 wins the first contention.
  - rvalid0=rvalid1=0, rdata0=rdata1=0, busy=0, wait counters=0.
- Arbitration is round-robin, evaluated every cycle with no state machine beyond rr_last:
  - Only one requester active: it is granted.
  - Both active: grant the port != rr_last.
  - On every grant, rr_last <= granted port at the clock edge.
  - No request: rr_last holds.
- gnt0 and gnt1 are mutually exclusive, both 0 when there is no request, and never asserted without the corresponding req.
- Ungranted requester must hold req and addr; the arbiter does not queue requests.
- Granted in cycle N:
  - rom_addr <= addr of the winner at the edge ending cycle N.
  - Tag {valid, port} enters a ROM_LAT+1 stage shift register.
  - rvalidX=1 in cycle N+1+ROM_LAT only (one-cycle pulse); rdataX=rom_data in that cycle.
  - Non-owner rdata is driven 0.
  - ROM_LAT=1 gives rvalid at N+2.
- No grant: rom_addr holds its last value and a tag with valid=0 is shifted in.
- Throughput: one access per cycle; back-to-back grants to the same or alternating ports return in order, with no bubbles.
- busy = OR of tag-pipeline valid bits.
- Reset asserted mid-flight: all in-flight tags are discarded and no rvalid follows after release. The first request after release is granted in the same cycle.
- rom_addr is never X after reset.

Optional Feature:
- Macro FONT_ARB_PORT0_PRIO_EN.
- Defined:
  - Port 0 has fixed priority.
  - Per-port 4-bit wait counter: increments each cycle the port requests and is not granted; clears on grant or when req drops.
  - When wait1 reaches MAX_WAIT, port 1 is granted for one cycle regardless of req0; rr_last is unused.
- Undefined: pure round-robin as above; counters are not built.

Test Plan:
- Reset then idle → after rst release: gnt0=gnt1=0, rvalid0=rvalid1=0, busy=0, rom_addr=0.
- req0 only, addr0=13'h0A5, ROM model returns addr-derived pattern → gnt0=1 in cycle N, rom_addr=13'h0A5 at N+1, rvalid0=1 for exactly cycle N+2 with matching data, rvalid1 stays 0.
- req0 and req1 held for 6 cycles from reset, addresses 13'h010 and 13'h020 → grants alternate 0,1,0,1,0,1; returned data is steered to the correct port, with rvalid pulses one per grant at the +2 offset.
- ROM_LAT=3, continuous alternating requests → rvalid at N+4, busy=1 throughout, no dropped or duplicated returns.
- rst pulsed low for 1 cycle with two accesses in flight → no rvalid after release; the next req1 is granted the same cycle.
- With FONT_ARB_PORT0_PRIO_EN, MAX_WAIT=3, req0 and req1 held → gnt0 for 3 cycles, gnt1 on the 4th, pattern repeats. Without the macro the same stimulus alternates.
